unibus_master: RTL and testbench

ARM-commanded Unibus master: the initiator side of the MSYN/SSYN protocol that the I/O register slaves answer. Each ARM command acquires the bus by NPR arbitration and performs one DATI, DATO or DATOB cycle. It also watches for a missing SSYN and reports the result in a status word. It sits beside the slave devices on the same ARM register bus and Unibus signal set.

---
 rtl/unibus_master_pkg.sv | 12 +
 rtl/unibus_master_timer.sv | 24 ++
 rtl/unibus_master.sv | 158 +++++++++++++++
 tb/tb_unibus_master.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/unibus_master_pkg.sv
// Shared state encoding and constants for the ARM-commanded Unibus master.
package unibus_master_pkg;

    typedef enum logic [2:0] {IDLE, REQ, SACK, SETUP, WAIT, HOLD, END} state_t;

    localparam logic [1:0]  DATI  = 2'b00;
    localparam logic [1:0]  DATO  = 2'b10;
    localparam logic [1:0]  DATOB = 2'b11;

    localparam logic [31:0] UNIBUS_MASTER_ID = 32'h554D1001;

endpackage

// File: rtl/unibus_master_timer.sv
// Loadable 16-bit down-counter with zero flag; holds at zero.
module unibus_master_timer (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        dec,
    output logic        zero
);

    logic [15:0] count;

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (dec && count != '0)
            count <= count - 16'd1;
    end

    assign zero = (count == '0);

endmodule

// File: rtl/unibus_master.sv
// Unibus master: NPR arbitration then one DATI/DATO/DATOB cycle per ARM command.
// Define UNIBUS_MASTER_TIMEOUT_EN to abort a WAIT with no SSYN after TIMEOUT clocks.
module unibus_master
    import unibus_master_pkg::*;
#(
    parameter int DESKEW  = 15,
    parameter int TIMEOUT = 1000
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        armwrite,
    input  logic [1:0]  armraddr,
    input  logic [1:0]  armwaddr,
    input  logic [31:0] armwdata,
    output logic [31:0] armrdata,
    input  logic        npg_in_h,
    input  logic        bbsy_in_h,
    input  logic        ssyn_in_h,
    input  logic        init_in_h,
    input  logic [15:0] d_in_h,
    output logic        npr_out_h,
    output logic        sack_out_h,
    output logic        bbsy_out_h,
    output logic        msyn_out_h,
    output logic [17:0] a_out_h,
    output logic [1:0]  c_out_h,
    output logic [15:0] d_out_h
);

    state_t      state, state_nxt;
    logic        busy, done, error, aborted, enable;
    logic [17:0] addr;
    logic [1:0]  cyc_type;
    logic [15:0] wdata, rdata;
    logic        tmr_load, tmr_dec, tmr_zero;
    logic [15:0] tmr_val;
    logic        complete, abort, capture, timed_out;
    logic        arm_wr, start, on_bus;

    assign arm_wr = armwrite && !init_in_h;
    assign start  = arm_wr && armwaddr == 2'd1 && armwdata[31] && !busy && enable;

    unibus_master_timer u_timer (
        .CLOCK    (CLOCK),
        .RESET    (RESET),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    // Loading N gives N+1 clocks in the state before the zero flag moves it on.
    always_comb begin
        state_nxt = state;
        tmr_load  = 1'b0;
        tmr_val   = 16'(DESKEW);
        tmr_dec   = 1'b0;
        complete  = 1'b0;
        capture   = 1'b0;
        timed_out = 1'b0;
        abort     = 1'b0;
        unique case (state)
            IDLE:  if (start) state_nxt = REQ;
            REQ:   if (npg_in_h) state_nxt = SACK;
            SACK:  if (!bbsy_in_h && !ssyn_in_h) begin
                       state_nxt = SETUP;
                       tmr_load  = 1'b1;
                   end
            SETUP: if (tmr_zero) begin
                       state_nxt = WAIT;
                       tmr_load  = 1'b1;
                       tmr_val   = 16'(TIMEOUT - 1);
                   end else
                       tmr_dec = 1'b1;
            WAIT:  if (ssyn_in_h) begin
                       state_nxt = HOLD;
                       capture   = (cyc_type == DATI);
                       tmr_load  = 1'b1;
                   end
`ifdef UNIBUS_MASTER_TIMEOUT_EN
                   else if (tmr_zero) begin
                       state_nxt = END;
                       timed_out = 1'b1;
                   end else
                       tmr_dec = 1'b1;
`endif
            HOLD:  if (tmr_zero) state_nxt = END;
                   else          tmr_dec   = 1'b1;
            END:   if (!ssyn_in_h) begin
                       state_nxt = IDLE;
                       complete  = 1'b1;
                   end
            default: state_nxt = IDLE;
        endcase
        if (state != IDLE && init_in_h) begin
            state_nxt = IDLE;
            abort     = 1'b1;
            complete  = 1'b0;
            capture   = 1'b0;
            timed_out = 1'b0;
            tmr_load  = 1'b0;
            tmr_dec   = 1'b0;
        end
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            aborted  <= 1'b0;
            enable   <= 1'b0;
            addr     <= '0;
            cyc_type <= '0;
            wdata    <= '0;
            rdata    <= '0;
        end else begin
            state <= state_nxt;
            if (start) begin
                busy     <= 1'b1;
                done     <= 1'b0;
                error    <= 1'b0;
                aborted  <= 1'b0;
                addr     <= armwdata[17:0];
                cyc_type <= armwdata[30:29];
            end
            if (complete || abort) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
            if (abort)     aborted <= 1'b1;
            if (timed_out) error   <= 1'b1;
            if (capture)   rdata   <= d_in_h;
            if (arm_wr && armwaddr == 2'd2) wdata  <= armwdata[31:16];
            if (arm_wr && armwaddr == 2'd3) enable <= armwdata[31];
        end
    end

    assign on_bus     = state inside {SETUP, WAIT, HOLD, END};
    assign npr_out_h  = (state == REQ);
    assign sack_out_h = (state == SACK);
    assign bbsy_out_h = on_bus;
    assign msyn_out_h = state inside {WAIT, HOLD};
    assign a_out_h    = on_bus ? addr : '0;
    assign c_out_h    = on_bus ? cyc_type : '0;
    assign d_out_h    = (on_bus && cyc_type[1]) ? wdata : '0;

    always_comb begin
        unique case (armraddr)
            2'd0: armrdata = UNIBUS_MASTER_ID;
            2'd1: armrdata = {busy, done, error, aborted, 10'b0, addr};
            2'd2: armrdata = {wdata, rdata};
            2'd3: armrdata = {enable, 31'b0};
        endcase
    end

endmodule

// File: tb/tb_unibus_master.sv
// Scoreboard bench for unibus_master: bus-output events and ARM reads are queued and checked by a monitor.
module tb_unibus_master;

    localparam int          D     = 15;
    localparam int          TMO   = 1000;
    localparam logic [31:0] ID    = 32'h554D1001;
    localparam logic [1:0]  C_DATI  = 2'b00;
    localparam logic [1:0]  C_DATO  = 2'b10;
    localparam logic [1:0]  C_DATOB = 2'b11;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b1;
    logic        armwrite = 1'b0;
    logic [1:0]  armraddr = 2'd0, armwaddr = 2'd0;
    logic [31:0] armwdata = '0;
    logic [31:0] armrdata;
    logic        npg_in_h = 1'b0, bbsy_in_h = 1'b0, ssyn_in_h = 1'b0, init_in_h = 1'b0;
    logic [15:0] d_in_h = '0;
    logic        npr_out_h, sack_out_h, bbsy_out_h, msyn_out_h;
    logic [17:0] a_out_h;
    logic [1:0]  c_out_h;
    logic [15:0] d_out_h;

    always #5 CLOCK = ~CLOCK;

    unibus_master #(.DESKEW(D), .TIMEOUT(TMO)) dut (
        .CLOCK      (CLOCK),
        .RESET      (RESET),
        .armwrite   (armwrite),
        .armraddr   (armraddr),
        .armwaddr   (armwaddr),
        .armwdata   (armwdata),
        .armrdata   (armrdata),
        .npg_in_h   (npg_in_h),
        .bbsy_in_h  (bbsy_in_h),
        .ssyn_in_h  (ssyn_in_h),
        .init_in_h  (init_in_h),
        .d_in_h     (d_in_h),
        .npr_out_h  (npr_out_h),
        .sack_out_h (sack_out_h),
        .bbsy_out_h (bbsy_out_h),
        .msyn_out_h (msyn_out_h),
        .a_out_h    (a_out_h),
        .c_out_h    (c_out_h),
        .d_out_h    (d_out_h)
    );

    typedef struct { logic [39:0] vec; int at; string name; } ev_t;
    typedef struct { logic [31:0] val; string name; } rd_t;

    ev_t  evq[$];
    rd_t  rdq[$];
    int   total = 0, bad = 0, cyc = 0, stim_errs = 0;
    logic finish_req = 1'b0;

    always @(posedge CLOCK) cyc <= cyc + 1;

    function automatic logic [39:0] bus(input logic npr, input logic sack, input logic bbsy,
                                        input logic msyn, input logic [1:0] c,
                                        input logic [17:0] a, input logic [15:0] d);
        return {npr, sack, bbsy, msyn, c, a, d};
    endfunction

    function automatic logic [31:0] st(input logic b, input logic dn, input logic er,
                                       input logic ab, input logic [17:0] a);
        return {b, dn, er, ab, 10'b0, a};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [39:0] v, input int at, input string n);
        ev_t e;
        e.vec = v; e.at = at; e.name = n;
        evq.push_back(e);
    endtask

    // Monitor: every change of the bus outputs must match the next queued event and cycle.
    initial begin
        logic [39:0] cur;
        logic [39:0] prev_bv;
        ev_t e;
        rd_t r;
        prev_bv = '0;
        forever begin
            @(negedge CLOCK or negedge RESET);
            #1;
            cur = {npr_out_h, sack_out_h, bbsy_out_h, msyn_out_h, c_out_h, a_out_h, d_out_h};
            if (!RESET && !CLOCK) chk("reset_bus", cur, '0);
            if (cur !== prev_bv) begin
                if (evq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_bus_event: got %h want unchanged %h at cycle %0d", cur, prev_bv, cyc);
                end else begin
                    e = evq.pop_front();
                    chk({e.name, "_bus"}, cur, e.vec);
                    chk({e.name, "_cycle"}, cyc, e.at);
                end
            end
            prev_bv = cur;
            if (!CLOCK && rdq.size() > 0) begin
                r = rdq.pop_front();
                chk(r.name, armrdata, r.val);
            end
            if (finish_req && !CLOCK) begin
                chk("events_left", evq.size(), 0);
                chk("stimulus_waits", stim_errs, 0);
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    task automatic tick;
        @(posedge CLOCK);
        #1;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] v, input string n);
        rd_t r;
        armraddr = a;
        r.val = v; r.name = n;
        rdq.push_back(r);
        @(negedge CLOCK);
        #2;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] v);
        armwaddr = a; armwdata = v; armwrite = 1'b1;
        tick;
        armwrite = 1'b0;
    endtask

    // mode 0 normal, 1 init pulse in WAIT, 2 RESET in HOLD, 3 no SSYN (timeout)
    task automatic run_cycle(input int mode, input logic [1:0] c, input logic [17:0] a,
                             input int g, input int h, input int s,
                             input logic [15:0] din, input logic [15:0] wd, input string nm);
        logic [15:0] dx;
        int n;
        int m;
        dx = c[1] ? wd : 16'h0;
        tick;
        if (h > 0) bbsy_in_h = 1'b1;
        push(bus(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 18'h0, 16'h0), cyc + 1, {nm, "_npr"});
        armwaddr = 2'd1; armwdata = {1'b1, c, 11'b0, a}; armwrite = 1'b1;
        tick;
        armwrite = 1'b0;
        repeat (g) tick;
        npg_in_h = 1'b1;
        push(bus(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 18'h0, 16'h0), cyc + 1, {nm, "_sack"});
        tick;
        npg_in_h = 1'b0;
        for (int i = 0; i < h; i++) begin
            if (i == 5) begin
                armwaddr = 2'd1; armwdata = {1'b1, 2'b00, 11'b0, 18'o000001}; armwrite = 1'b1;
            end
            tick;
            armwrite = 1'b0;
        end
        bbsy_in_h = 1'b0;
        push(bus(1'b0, 1'b0, 1'b1, 1'b0, c, a, dx), cyc + 1,     {nm, "_setup"});
        push(bus(1'b0, 1'b0, 1'b1, 1'b1, c, a, dx), cyc + 2 + D, {nm, "_msyn"});
        n = 0;
        while (!msyn_out_h && n < 200) begin tick; n++; end
        if (!msyn_out_h) begin
            stim_errs++;
            $display("FAIL %s_wait_msyn: msyn still low after %0d cycles", nm, n);
            return;
        end
        m = cyc;
        if (mode == 1) begin
            tick; tick;
            init_in_h = 1'b1;
            armwaddr = 2'd3; armwdata = 32'h0; armwrite = 1'b1;
            push('0, cyc + 1, {nm, "_init"});
            tick;
            init_in_h = 1'b0; armwrite = 1'b0;
            return;
        end
        if (mode == 3) begin
            push(bus(1'b0, 1'b0, 1'b1, 1'b0, c, a, dx), m + TMO,     {nm, "_msyn_drop"});
            push('0,                                    m + TMO + 1, {nm, "_release"});
            n = 0;
            while (msyn_out_h && n < TMO + 100) begin tick; n++; end
            if (msyn_out_h) begin
                stim_errs++;
                $display("FAIL %s_wait_timeout: msyn still high after %0d cycles", nm, n);
            end
            tick;
            return;
        end
        repeat (s - 1) tick;
        ssyn_in_h = 1'b1; d_in_h = din;
        if (mode == 2) begin
            repeat (3) tick;
            push('0, cyc, {nm, "_reset"});
            RESET = 1'b0;
            tick;
            ssyn_in_h = 1'b0; d_in_h = 16'h0;
            RESET = 1'b1;
            return;
        end
        push(bus(1'b0, 1'b0, 1'b1, 1'b0, c, a, dx), cyc + 2 + D, {nm, "_msyn_drop"});
        n = 0;
        while (msyn_out_h && n < 200) begin tick; n++; end
        if (msyn_out_h) begin
            stim_errs++;
            $display("FAIL %s_wait_drop: msyn still high after %0d cycles", nm, n);
            return;
        end
        ssyn_in_h = 1'b0; d_in_h = 16'h0;
        push('0, cyc + 1, {nm, "_release"});
        tick;
    endtask

    initial begin
        #1 RESET = 1'b0;
        repeat (3) tick;
        rd(2'd0, ID,    "id_reset");
        rd(2'd1, 32'h0, "status_reset");
        rd(2'd2, 32'h0, "data_reset");
        rd(2'd3, 32'h0, "enable_reset");
        tick;
        RESET = 1'b1;
        tick;

        wr(2'd3, 32'h8000_0000);
        rd(2'd3, 32'h8000_0000, "enable_set");

        run_cycle(0, C_DATI, 18'o777560, 3, 0, 5, 16'o000200, 16'h0, "dati");
        rd(2'd1, st(1'b0, 1'b1, 1'b0, 1'b0, 18'o777560), "dati_status");
        rd(2'd2, {16'h0, 16'o000200}, "dati_rdata");

        wr(2'd2, {16'o000101, 16'h0});
        run_cycle(0, C_DATOB, 18'o777567, 0, 0, 2, 16'o177777, 16'o000101, "datob");
        rd(2'd1, st(1'b0, 1'b1, 1'b0, 1'b0, 18'o777567), "datob_status");
        rd(2'd2, {16'o000101, 16'o000200}, "datob_data");

        wr(2'd2, {16'o123456, 16'h0});
        run_cycle(0, C_DATO, 18'o001000, 1, 20, 1, 16'h0, 16'o123456, "holdoff");
        rd(2'd1, st(1'b0, 1'b1, 1'b0, 1'b0, 18'o001000), "holdoff_status");

        run_cycle(1, C_DATI, 18'o000400, 0, 0, 1, 16'h0, 16'h0, "initwait");
        rd(2'd1, st(1'b0, 1'b1, 1'b0, 1'b1, 18'o000400), "init_status");
        rd(2'd3, 32'h8000_0000, "init_write_dropped");

        run_cycle(0, C_DATI, 18'o000402, 0, 0, 3, 16'o052525, 16'h0, "after_init");
        rd(2'd1, st(1'b0, 1'b1, 1'b0, 1'b0, 18'o000402), "after_init_status");
        rd(2'd2, {16'o123456, 16'o052525}, "after_init_rdata");

        tick;
        init_in_h = 1'b1;
        tick;
        init_in_h = 1'b0;
        rd(2'd1, st(1'b0, 1'b1, 1'b0, 1'b0, 18'o000402), "idle_init_no_effect");

        run_cycle(2, C_DATI, 18'o000404, 0, 0, 2, 16'o000007, 16'h0, "reset_hold");
        rd(2'd3, 32'h0, "reset_enable");
        rd(2'd1, 32'h0, "reset_status");

        wr(2'd1, {1'b1, C_DATI, 11'b0, 18'o000406});
        repeat (4) tick;
        rd(2'd1, 32'h0, "start_ignored_disabled");

        wr(2'd3, 32'h8000_0000);
        run_cycle(0, C_DATI, 18'o000406, 2, 0, 1, 16'o000777, 16'h0, "reenabled");
        rd(2'd1, st(1'b0, 1'b1, 1'b0, 1'b0, 18'o000406), "reenabled_status");
        rd(2'd2, {16'h0, 16'o000777}, "reenabled_rdata");

`ifdef UNIBUS_MASTER_TIMEOUT_EN
        run_cycle(3, C_DATI, 18'o000410, 0, 0, 1, 16'h0, 16'h0, "timeout");
        rd(2'd1, st(1'b0, 1'b1, 1'b1, 1'b0, 18'o000410), "timeout_status");
        rd(2'd2, {16'h0, 16'o000777}, "timeout_rdata");
`endif

        repeat (3) tick;
        finish_req = 1'b1;
    end

endmodule
